scan_doubler: RTL

// - Downstream of the video generator: takes its 7 MHz pixel stream (blank[1:0], sync[1:0], rgb[23:0]) and emits

---
 rtl/scan_doubler_if.sv | 25 ++
 rtl/scan_doubler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/scan_doubler_if.sv
// Pixel-stream bundle between the video generator (master) and the scan doubler (slave).
interface scan_doubler_if #(
   parameter int unsigned CW = 24
);
   logic          ceIn;
   logic          ceOut;
   logic          enable;
   logic          scanlines;
   logic [1:0]    blankIn;
   logic [1:0]    syncIn;
   logic [CW-1:0] rgbIn;
   logic [1:0]    blankOut;
   logic [1:0]    syncOut;
   logic [CW-1:0] rgbOut;

   modport master (
      output ceIn, ceOut, enable, scanlines, blankIn, syncIn, rgbIn,
      input  blankOut, syncOut, rgbOut
   );

   modport slave (
      input  ceIn, ceOut, enable, scanlines, blankIn, syncIn, rgbIn,
      output blankOut, syncOut, rgbOut
   );
endinterface

// File: rtl/scan_doubler.sv
// Line doubler: writes each input line into one bank of a ping-pong buffer while the other bank
// is replayed twice at the output pixel rate, with optional scanline darkening and a bypass.
module scan_doubler #(
   parameter int unsigned AW = 9,
   parameter int unsigned CW = 24
) (
   input logic           clock,
   input logic           reset,
   scan_doubler_if.slave vid
);
   localparam int unsigned HW = AW + 1;
   localparam int unsigned Depth = 2 ** AW;
   localparam int unsigned ChW = CW / 3;
   localparam logic [HW-1:0] HSat = HW'((2 ** HW) - 2);
   localparam logic [HW-1:0] HDepth = HW'(Depth);

   logic [CW-1:0] mem [2 * Depth];

   logic          wr_bank_q, sync_prev_q, hb_prev_q, line_valid_q, doubling_q;
   logic [HW-1:0] h_in_q, sync_cnt_q, hb_start_cur_q, hb_end_cur_q;
   logic          vb_cur_q, vs_cur_q, vb_buf_q, vs_buf_q;
   logic [HW-1:0] line_len_q, sync_len_q, hb_start_q, hb_end_q;
   logic [HW-1:0] h_out_q;
   logic          line_odd_q;
   logic [1:0]    blank_q, sync_q;
   logic [CW-1:0] rgb_q;

   logic          hs_rise, hb_rise, hb_fall, wr_en, wr_sel;
   logic [HW-1:0] h_next;
   logic [CW-1:0] rd_pix, dark_pix, out_pix;
   logic [1:0]    blank_dbl, sync_dbl;

   // Input side: h_next is the index of the pixel sampled this ceIn; the hsync edge pixel is 0.
   always_comb begin
      hs_rise = vid.ceIn && vid.syncIn[0] && !sync_prev_q;
      hb_rise = vid.ceIn && vid.blankIn[0] && !hb_prev_q;
      hb_fall = vid.ceIn && !vid.blankIn[0] && hb_prev_q;
      if (hs_rise) begin
         h_next = '0;
      end else if (h_in_q >= HSat) begin
         h_next = HSat;
      end else begin
         h_next = h_in_q + 1'b1;
      end
      wr_sel = hs_rise ? ~wr_bank_q : wr_bank_q;
      wr_en  = vid.ceIn && (h_next < HDepth);
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[{wr_sel, h_next[AW-1:0]}] <= vid.rgbIn;
      end
   end

   // Output side: replay bank ~wr_bank; addresses past the buffer read as black.
   always_comb begin
      rd_pix   = '0;
      dark_pix = '0;
      if (h_out_q < HDepth) begin
         rd_pix = mem[{~wr_bank_q, h_out_q[AW-1:0]}];
      end
      for (int k = 0; k < 3; k++) begin
         dark_pix[k*ChW +: ChW] = {1'b0, rd_pix[k*ChW+1 +: ChW-1]};
      end
      out_pix   = (vid.scanlines && line_odd_q) ? dark_pix : rd_pix;
      sync_dbl  = {vs_buf_q, h_out_q < sync_len_q};
      blank_dbl = {vb_buf_q, !(h_out_q >= hb_end_q && h_out_q < hb_start_q)};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_bank_q      <= 1'b0;
         sync_prev_q    <= 1'b0;
         hb_prev_q      <= 1'b0;
         line_valid_q   <= 1'b0;
         doubling_q     <= 1'b1;
         h_in_q         <= '0;
         sync_cnt_q     <= '0;
         hb_start_cur_q <= '0;
         hb_end_cur_q   <= '0;
         vb_cur_q       <= 1'b0;
         vs_cur_q       <= 1'b0;
         vb_buf_q       <= 1'b0;
         vs_buf_q       <= 1'b0;
         line_len_q     <= '0;
         sync_len_q     <= '0;
         hb_start_q     <= '0;
         hb_end_q       <= '0;
         h_out_q        <= '0;
         line_odd_q     <= 1'b0;
         blank_q        <= 2'b11;
         sync_q         <= 2'b00;
         rgb_q          <= '0;
      end else begin
         if (vid.ceIn) begin
            sync_prev_q <= vid.syncIn[0];
            hb_prev_q   <= vid.blankIn[0];
            h_in_q      <= h_next;
            if (hb_rise) hb_start_cur_q <= h_next;
            if (hb_fall) hb_end_cur_q <= h_next;
            if (hs_rise) begin
               // Commit the finished line; the partial line seen after reset is discarded.
               wr_bank_q    <= ~wr_bank_q;
               line_valid_q <= 1'b1;
               line_len_q   <= line_valid_q ? h_in_q + 1'b1 : '0;
               sync_len_q   <= sync_cnt_q;
               hb_start_q   <= hb_start_cur_q;
               hb_end_q     <= hb_end_cur_q;
               vb_buf_q     <= vb_cur_q;
               vs_buf_q     <= vs_cur_q;
               vb_cur_q     <= vid.blankIn[1];
               vs_cur_q     <= vid.syncIn[1];
               sync_cnt_q   <= HW'(1);
               doubling_q   <= vid.enable;
            end else if (vid.syncIn[0] && sync_cnt_q != '1) begin
               sync_cnt_q <= sync_cnt_q + 1'b1;
            end
         end

         if (hs_rise) begin
            h_out_q    <= '0;
            line_odd_q <= 1'b0;
         end else if (vid.ceOut) begin
            if (line_len_q == '0) begin
               h_out_q    <= '0;
               line_odd_q <= 1'b0;
            end else if (h_out_q == line_len_q - 1'b1) begin
               h_out_q    <= '0;
               line_odd_q <= ~line_odd_q;
            end else begin
               h_out_q <= h_out_q + 1'b1;
            end
         end

         if (!doubling_q) begin
            if (vid.ceIn) begin
               blank_q <= vid.blankIn;
               sync_q  <= vid.syncIn;
               rgb_q   <= (|vid.blankIn) ? '0 : vid.rgbIn;
            end
         end else if (vid.ceOut) begin
            if (line_len_q == '0) begin
               blank_q <= 2'b11;
               sync_q  <= 2'b00;
               rgb_q   <= '0;
            end else begin
               blank_q <= blank_dbl;
               sync_q  <= sync_dbl;
               rgb_q   <= (|blank_dbl) ? '0 : out_pix;
            end
         end
      end
   end

   assign vid.blankOut = blank_q;
   assign vid.syncOut  = sync_q;
   assign vid.rgbOut   = rgb_q;

endmodule
